// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// - hz_state_e : controller FSM state encoding
// - Nop        : canonical NOP (addi x0,x0,0) loaded into IF_ID on a flush
// - Opc*       : RV32 major opcodes used upstream to derive id_uses_rs2
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalt    = 2'd2
  } hz_state_e;

  localparam logic [31:0] Nop = 32'h0000_0013;

  localparam logic [6:0] OpcLoad   = 7'b000_0011;
  localparam logic [6:0] OpcOpImm  = 7'b001_0011;
  localparam logic [6:0] OpcStore  = 7'b010_0011;
  localparam logic [6:0] OpcOp     = 7'b011_0011;
  localparam logic [6:0] OpcBranch = 7'b110_0011;

  // True when an instruction with this opcode reads rs2 (R-type, store, branch).
  function automatic logic uses_rs2_f(input logic [6:0] opc);
    unique case (opc)
      OpcOp, OpcStore, OpcBranch: return 1'b1;
      OpcLoad, OpcOpImm:          return 1'b0;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master : pipeline side (drives ID/EX/MEM state, receives stage controls)
// slave  : controller side (reads pipeline state, drives stage controls)
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  // Pipeline state seen by the controller
  logic [4:0]       if_id_rs1;
  logic [4:0]       if_id_rs2;
  logic             id_uses_rs2;
  logic             id_is_branch;
  logic             branch_taken;
  logic             id_ex_regw;
  logic             id_ex_memr;
  logic [4:0]       id_ex_rd;
  logic             ex_mem_memr;
  logic             ex_mem_memw;
  logic [4:0]       ex_mem_rd;
  logic             dmem_ready;
  // Stage controls and status
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_bubble;
  logic             ex_mem_write;
  logic             mem_wb_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output if_id_rs1, if_id_rs2, id_uses_rs2, id_is_branch, branch_taken,
           id_ex_regw, id_ex_memr, id_ex_rd, ex_mem_memr, ex_mem_memw, ex_mem_rd, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write,
           mem_wb_bubble, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  if_id_rs1, if_id_rs2, id_uses_rs2, id_is_branch, branch_taken,
           id_ex_regw, id_ex_memr, id_ex_rd, ex_mem_memr, ex_mem_memw, ex_mem_rd, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write,
           mem_wb_bubble, mem_timeout, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// clk_i : clock
// clr_i : synchronous clear (dominates en_i)
// en_i  : count enable; holds at all-ones instead of wrapping
// cnt_o : current count
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core.
// Detects load-use and branch-operand hazards, flushes IF/ID on a taken ID branch and
// freezes the pipeline while a data-memory access is pending. A memory access that stays
// pending for MAX_WAIT cycles parks the controller in a sticky halt until reset.
// clk   : clock
// reset : synchronous, active-high reset
// bus   : hazard_ctrl_if slave (pipeline state in, stage controls and counters out)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] MaxWait = WaitW'(MAX_WAIT);

  hz_state_e        state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;

  logic lu, br, busy;
  logic id_ex_hit, ex_mem_hit;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic ex_mem_write, mem_wb_bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // x0 is hard-wired, so a zero destination never creates a dependency.
  always_comb begin
    id_ex_hit  = (bus.id_ex_rd != 5'd0) &&
                 ((bus.id_ex_rd == bus.if_id_rs1) ||
                  (bus.id_uses_rs2 && (bus.id_ex_rd == bus.if_id_rs2)));
    ex_mem_hit = (bus.ex_mem_rd != 5'd0) &&
                 ((bus.ex_mem_rd == bus.if_id_rs1) ||
                  (bus.id_uses_rs2 && (bus.ex_mem_rd == bus.if_id_rs2)));
    lu   = bus.id_ex_memr && id_ex_hit;
    // Branches compare in ID, so they also wait on ALU results and on loads one stage later.
    br   = bus.id_is_branch &&
           ((bus.id_ex_regw && id_ex_hit) || (bus.ex_mem_memr && ex_mem_hit));
    busy = (bus.ex_mem_memr || bus.ex_mem_memw) && !bus.dmem_ready;
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    state_d       = state_q;
    wait_d        = wait_q;
    timeout_d     = timeout_q;

    unique case (state_q)
      StRun, StMemWait: begin
        if (busy) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_write  = 1'b0;
          mem_wb_bubble = 1'b1;
          wait_d        = (state_q == StRun) ? WaitW'(1) : wait_q + 1'b1;
          if (wait_d >= MaxWait) begin
            state_d   = StHalt;
            timeout_d = 1'b1;
          end else begin
            state_d   = StMemWait;
          end
        end else begin
          // Memory done (or never pending): normal RUN rules apply this same cycle.
          state_d = StRun;
          if (lu || br) begin
            // Branch outcome is computed from stale operands here, so it is ignored.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (bus.branch_taken) begin
            if_id_flush  = 1'b1;
          end
        end
      end
      StHalt: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_bubble = 1'b1;
      end
      default: state_d = StRun;
    endcase

    if (reset) begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_bubble  = 1'b0;
      ex_mem_write  = 1'b1;
      mem_wb_bubble = 1'b0;
      state_d       = StRun;
      wait_d        = '0;
      timeout_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    wait_q    <= wait_d;
    timeout_q <= timeout_d;
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk),
    .clr_i (reset),
    .en_i  (!pc_write),
    .cnt_o (stall_cnt)
  );

  sat_counter #(
    .Width (CNT_W)
  ) u_flush_cnt (
    .clk_i (clk),
    .clr_i (reset),
    .en_i  (if_id_flush),
    .cnt_o (flush_cnt)
  );

  assign bus.pc_write      = pc_write;
  assign bus.if_id_write   = if_id_write;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_write   = id_ex_write;
  assign bus.id_ex_bubble  = id_ex_bubble;
  assign bus.ex_mem_write  = ex_mem_write;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.mem_timeout   = timeout_q && !reset;
  assign bus.stall_cnt     = stall_cnt;
  assign bus.flush_cnt     = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (CNT_W=4, MAX_WAIT=4). Each step pushes the expected
// control vector and counter values into a scoreboard, then pops and checks them once the
// combinational outputs have settled on the falling edge.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] CntMax = '1;

  // Control vector: {pc_w, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, memwb_bubble, tmo}
  localparam logic [7:0] Def    = 8'b1101_0100;
  localparam logic [7:0] Stall  = 8'b0001_1100;
  localparam logic [7:0] Flush  = 8'b1111_0100;
  localparam logic [7:0] Freeze = 8'b0000_0010;
  localparam logic [7:0] Halt   = 8'b0000_0011;

  localparam logic [31:0] InstAdd    = 32'h0012_8333;  // add  x6,x5,x1
  localparam logic [31:0] InstAddi   = 32'h0050_8313;  // addi x6,x1,5 (rs2 field = 5)
  localparam logic [31:0] InstBeqX7  = 32'h0003_8463;  // beq  x7,x0,+8
  localparam logic [31:0] InstBeqX0  = 32'h0000_0463;  // beq  x0,x0,+8
  localparam logic [31:0] InstBeqX3  = 32'h0030_0463;  // beq  x0,x3,+8

  typedef struct packed {
    logic [7:0]      ctl;
    logic [CntW-1:0] stall;
    logic [CntW-1:0] flush;
  } sb_t;

  logic clk;
  logic reset;
  logic [31:0] id_instr;
  sb_t  sb[$];
  logic [CntW-1:0] exp_stall, exp_flush;
  int   n_assert;
  int   n_fail;

  hazard_ctrl_if #(.CNT_W(CntW)) bus ();

  hazard_ctrl #(
    .CNT_W    (CntW),
    .MAX_WAIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_instr(input logic [31:0] instr);
    logic [6:0] opc;
    id_instr         = instr;
    opc              = id_instr[6:0];
    bus.if_id_rs1    = id_instr[19:15];
    bus.if_id_rs2    = id_instr[24:20];
    bus.id_uses_rs2  = uses_rs2_f(opc);
    bus.id_is_branch = (opc == OpcBranch);
  endtask

  task automatic idle();
    set_instr(Nop);
    bus.branch_taken = 1'b0;
    bus.id_ex_regw   = 1'b0;
    bus.id_ex_memr   = 1'b0;
    bus.id_ex_rd     = 5'd0;
    bus.ex_mem_memr  = 1'b0;
    bus.ex_mem_memw  = 1'b0;
    bus.ex_mem_rd    = 5'd0;
    bus.dmem_ready   = 1'b1;
  endtask

  // Load in EX feeding rs1 of an add in ID.
  task automatic load_use();
    idle();
    set_instr(InstAdd);
    bus.id_ex_memr = 1'b1;
    bus.id_ex_regw = 1'b1;
    bus.id_ex_rd   = 5'd5;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] ctl);
    sb_t e;
    logic [7:0] obs;
    sb.push_back('{ctl: ctl, stall: exp_stall, flush: exp_flush});
    @(negedge clk);
    e   = sb.pop_front();
    obs = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write, bus.id_ex_bubble,
           bus.ex_mem_write, bus.mem_wb_bubble, bus.mem_timeout};
    chk({tag, ".ctl"}, obs, e.ctl);
    chk({tag, ".stall_cnt"}, 8'(bus.stall_cnt), 8'(e.stall));
    chk({tag, ".flush_cnt"}, 8'(bus.flush_cnt), 8'(e.flush));
    // Counter model: advanced by the edge that ends this step.
    if (reset) begin
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      if (!ctl[7] && exp_stall != CntMax) exp_stall = exp_stall + 1'b1;
      if (ctl[5] && exp_flush != CntMax) exp_flush = exp_flush + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    exp_stall = '0;
    exp_flush = '0;
    reset     = 1'b1;
    idle();
    @(posedge clk);
    #1;

    // Reset dominates a pending memory access and a load-use hazard.
    load_use();
    bus.ex_mem_memw = 1'b1;
    bus.dmem_ready  = 1'b0;
    step("reset_dominates", Def);
    reset = 1'b0;
    idle();
    step("idle", Def);

    // lw x5; add x6,x5,x1 -> one bubble, then the add proceeds.
    load_use();
    step("load_use", Stall);
    idle();
    set_instr(InstAdd);
    bus.ex_mem_memr = 1'b1;
    bus.ex_mem_rd   = 5'd5;
    step("load_use_release", Def);

    // rs2 field matches but the I-type does not read rs2.
    load_use();
    set_instr(InstAddi);
    step("no_rs2_use", Def);

    // x0 destination never matches.
    idle();
    set_instr(InstBeqX0);
    bus.id_ex_memr = 1'b1;
    bus.id_ex_regw = 1'b1;
    step("rd_zero", Def);

    // addi x7; beq x7 -> one stall, taken ignored while stalled.
    idle();
    set_instr(InstBeqX7);
    bus.id_ex_regw   = 1'b1;
    bus.id_ex_rd     = 5'd7;
    bus.branch_taken = 1'b1;
    step("br_alu", Stall);
    idle();
    set_instr(InstBeqX7);
    bus.ex_mem_rd = 5'd7;
    step("br_alu_release", Def);

    // lw x7; beq x7 -> two stalls (id_ex term, then ex_mem load term).
    idle();
    set_instr(InstBeqX7);
    bus.id_ex_regw   = 1'b1;
    bus.id_ex_memr   = 1'b1;
    bus.id_ex_rd     = 5'd7;
    bus.branch_taken = 1'b1;
    step("br_load_1", Stall);
    idle();
    set_instr(InstBeqX7);
    bus.ex_mem_memr  = 1'b1;
    bus.ex_mem_rd    = 5'd7;
    bus.branch_taken = 1'b1;
    step("br_load_2", Stall);
    idle();
    set_instr(InstBeqX7);
    step("br_load_release", Def);

    // Branch operand hazard through rs2.
    idle();
    set_instr(InstBeqX3);
    bus.id_ex_regw = 1'b1;
    bus.id_ex_rd   = 5'd3;
    step("br_rs2", Stall);

    // Taken branch with no hazard -> single flush.
    idle();
    set_instr(InstBeqX0);
    bus.branch_taken = 1'b1;
    step("flush", Flush);
    idle();
    step("after_flush", Def);

    // Store waits 3 cycles; busy outranks a load-use hazard; release in ready cycle.
    load_use();
    bus.ex_mem_memw = 1'b1;
    bus.dmem_ready  = 1'b0;
    step("mem_wait_1", Freeze);
    idle();
    bus.ex_mem_memw = 1'b1;
    bus.dmem_ready  = 1'b0;
    step("mem_wait_2", Freeze);
    step("mem_wait_3", Freeze);
    bus.dmem_ready = 1'b1;
    step("mem_ready", Def);
    idle();
    step("after_mem", Def);

    // Ready cycle evaluates RUN rules, so a load-use hazard stalls there.
    idle();
    bus.ex_mem_memr = 1'b1;
    bus.ex_mem_rd   = 5'd9;
    bus.dmem_ready  = 1'b0;
    step("mem_wait_lu", Freeze);
    load_use();
    bus.ex_mem_memr = 1'b1;
    bus.ex_mem_rd   = 5'd9;
    step("mem_ready_lu", Stall);
    idle();
    step("after_mem_lu", Def);

    // Timeout: 4 busy cycles then sticky halt; ready does not release it.
    idle();
    bus.ex_mem_memw = 1'b1;
    bus.dmem_ready  = 1'b0;
    for (int i = 0; i < 4; i++) step("tmo_wait", Freeze);
    step("halt", Halt);
    idle();
    step("halt_sticky", Halt);
    reset = 1'b1;
    step("halt_reset", Def);
    reset = 1'b0;
    step("post_halt", Def);

    // Reset in the middle of a memory wait.
    bus.ex_mem_memw = 1'b1;
    bus.dmem_ready  = 1'b0;
    step("mw_before_reset", Freeze);
    reset = 1'b1;
    step("mw_reset", Def);
    reset = 1'b0;
    idle();
    step("mw_post_reset", Def);

    // Saturation: 2^4+5 stall cycles, then 2^4+1 flushes.
    load_use();
    for (int i = 0; i < 21; i++) step("sat_stall", Stall);
    idle();
    step("stall_sat", Def);
    set_instr(InstBeqX0);
    bus.branch_taken = 1'b1;
    for (int i = 0; i < 17; i++) step("sat_flush", Flush);
    idle();
    step("flush_sat", Def);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32 core. It detects load-use and branch-operand hazards, flushes IF/ID on a taken ID-stage branch, and freezes the whole pipeline while a variable-latency data memory access is pending. It drives the write-enable, bubble and flush inputs of PC, IF_ID, ID_EX, EX_MEM and MEM_WB. It also keeps saturating stall and flush performance counters and latches a sticky timeout error.

Parameters:
CNT_W, 16, width of the stall/flush performance counters
MAX_WAIT, 8, maximum consecutive memory-wait cycles before timeout (≥1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_id_rs1  in  5  rs1 field of instruction in ID
if_id_rs2  in  5  rs2 field of instruction in ID
id_uses_rs2  in  1  ID instruction reads rs2 (R-type, store, branch)
id_is_branch  in  1  Branch control output of ID instruction
branch_taken  in  1  PCSrc (Branch AND EqualFlag)
id_ex_regw  in  1  RegW in ID_EX
id_ex_memr  in  1  MemR in ID_EX
id_ex_rd  in  5  destination reg in ID_EX
ex_mem_memr  in  1  MemR in EX_MEM
ex_mem_memw  in  1  MemW in EX_MEM
ex_mem_rd  in  5  destination reg in EX_MEM
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC load enable
if_id_write  out  1  IF_ID load enable
if_id_flush  out  1  IF_ID loads NOP (0x00000013)
id_ex_write  out  1  ID_EX load enable
id_ex_bubble  out  1  ID_EX loads all control bits 0
ex_mem_write  out  1  EX_MEM load enable
mem_wb_bubble  out  1  MEM_WB loads RegW=0
mem_timeout  out  1  sticky error, data memory exceeded MAX_WAIT
stall_cnt  out  CNT_W  stall cycles (load-use + branch + memory), saturating
flush_cnt  out  CNT_W  IF_ID flushes, saturating

Behaviour:
- Hazard terms (combinational; rd==0 never matches):
  - m1(x) = x==if_id_rs1
  - m2(x) = id_uses_rs2 & x==if_id_rs2
  - lu = id_ex_memr & (m1|m2)(id_ex_rd)
  - br = id_is_branch & ((id_ex_regw & (m1|m2)(id_ex_rd)) | (ex_mem_memr & (m1|m2)(ex_mem_rd)))
  - busy = (ex_mem_memr|ex_mem_memw) & !dmem_ready
- Default outputs: writes=1, bubbles/flush=0.
- FSM states: RUN, MEM_WAIT, HALT. State is registered; outputs are combinational from state and inputs, so a stall takes effect in the cycle the hazard is present.
- RUN, priority order:
  - busy: freeze. pc_write, if_id_write, id_ex_write, ex_mem_write = 0; mem_wb_bubble = 1; next state MEM_WAIT; wait counter = 1.
  - else lu|br: pc_write = 0, if_id_write = 0, id_ex_bubble = 1. Any branch_taken is ignored because operands are stale.
  - else branch_taken: if_id_flush = 1, flush_cnt += 1.
- MEM_WAIT:
  - Freeze outputs as above while busy.
  - When dmem_ready=1, the freeze is released in that same cycle: outputs are evaluated with RUN rules and the next state is RUN.
  - The wait counter increments each busy cycle. If the counter reaches MAX_WAIT while still busy, next state is HALT and mem_timeout is set.
- HALT: permanent freeze (all writes 0, mem_wb_bubble = 1). mem_timeout = 1. Only reset exits.
- A branch hazard on a load in EX lasts 2 cycles: the first cycle via the id_ex term, the second via the ex_mem_memr term. A branch hazard on an ALU op lasts 1 cycle. A load-use hazard lasts 1 cycle.
- stall_cnt increments on every cycle with pc_write=0, including HALT. Both counters saturate at 2^CNT_W−1 with no wrap.
- Reset:
  - Next state RUN; counters, wait counter and mem_timeout cleared to 0.
  - While reset is high, outputs take the default values.
  - Reset mid-MEM_WAIT or mid-HALT returns to RUN on the next edge.
- Simultaneous lu and br: one stall cycle per cycle; stall_cnt increments by 1.

Decomposition:
- Shared package hazard_pkg holds:
  - state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2)
  - NOP constant 32'h00000013
  - opcode constants used to derive id_uses_rs2 upstream
- One natural sub-module: sat_counter (CNT_W-wide, enable, synchronous clear). It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- lw x5,0(x0); add x6,x5,x1 → exactly one cycle with pc_write=0, id_ex_bubble=1; stall_cnt=1; add then receives the forwarded value.
- addi x7,x0,3; beq x7,x0,L → 1 stall cycle. lw x7; beq x7,x0,L → 2 stall cycles; stall_cnt=2. The branch is not taken during the stall.
- beq x0,x0,+8 with no hazard, branch_taken=1 → if_id_flush=1 for 1 cycle; flush_cnt=1; PC=target.
- sw with dmem_ready low 3 cycles then high → 3 freeze cycles with mem_wb_bubble=1; RUN resumes in the ready cycle; stall_cnt=3.
- MAX_WAIT=4, dmem_ready held low → HALT after 4 cycles, mem_timeout=1, pc_write stays 0; reset pulse → RUN, mem_timeout=0, counters 0.
- Force 2^CNT_W+5 stall cycles (CNT_W=4) → stall_cnt holds 15.
